// File: rtl/ram_bus_arbiter.sv
// N-master arbiter for the shared RAM data port, with a read-return pipeline that routes data back to the issuing master.
// Define ARB_FIXED_PRIORITY_EN to replace round-robin with lowest-index-wins (no rr pointer).
module ram_bus_arbiter #(
    parameter  int N_MASTERS = 2,
    parameter  int ADDR_W    = 32,
    parameter  int DATA_W    = 32,
    parameter  int READ_LAT  = 1,
    localparam int MIDX_W    = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1,
    localparam int BE_W      = DATA_W / 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clk_en,
    input  logic                        i_lock_en,
    input  logic [MIDX_W-1:0]           i_lock_master,
    input  logic [N_MASTERS-1:0]        i_m_read_req,
    input  logic [N_MASTERS*ADDR_W-1:0] i_m_read_addr,
    input  logic [N_MASTERS-1:0]        i_m_write_enable,
    input  logic [N_MASTERS*BE_W-1:0]   i_m_byte_enable,
    input  logic [N_MASTERS*ADDR_W-1:0] i_m_write_addr,
    input  logic [N_MASTERS*DATA_W-1:0] i_m_write_data,
    output logic [N_MASTERS-1:0]        o_m_grant,
    output logic [N_MASTERS-1:0]        o_m_read_valid,
    output logic [DATA_W-1:0]           o_m_read_data,
    output logic                        o_read_req,
    output logic [ADDR_W-1:0]           o_read_addr,
    input  logic [DATA_W-1:0]           i_read_data,
    output logic                        o_write_enable,
    output logic [BE_W-1:0]             o_byte_enable,
    output logic [ADDR_W-1:0]           o_write_addr,
    output logic [DATA_W-1:0]           o_write_data
);

    logic [N_MASTERS-1:0] req;
    logic [N_MASTERS-1:0] elig;
    logic [MIDX_W-1:0]    start;
    logic [MIDX_W-1:0]    win;
    logic                 found;
    logic                 grant_ok;

    logic [READ_LAT-1:0]             vld_q;
    logic [READ_LAT-1:0][MIDX_W-1:0] idx_q;

    always_comb begin
        req  = i_m_read_req | i_m_write_enable;
        elig = '0;
        for (int unsigned k = 0; k < N_MASTERS; k++) begin
            if (!i_lock_en) begin
                elig[k] = req[k];
            end else if (32'(i_lock_master) == k) begin
                elig[k] = req[k];
            end
        end
    end

    // Search upward from start, wrapping at N_MASTERS-1; start is 0 in fixed-priority mode.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int unsigned i = 0; i < N_MASTERS; i++) begin
            int unsigned idx;
            idx = 32'(start) + i;
            if (idx >= 32'(N_MASTERS)) begin
                idx = idx - 32'(N_MASTERS);
            end
            if (!found && elig[idx[MIDX_W-1:0]]) begin
                found = 1'b1;
                win   = idx[MIDX_W-1:0];
            end
        end
    end

    assign grant_ok = found & clk_en & rst;

`ifdef ARB_FIXED_PRIORITY_EN
    assign start = '0;
`else
    logic [MIDX_W-1:0] rr_ptr_q;
    logic [MIDX_W-1:0] rr_ptr_d;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_ok) begin
            rr_ptr_d = (32'(win) == 32'(N_MASTERS - 1)) ? '0 : win + MIDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign start = rr_ptr_q;
`endif

    always_comb begin
        o_m_grant      = '0;
        o_read_req     = 1'b0;
        o_read_addr    = '0;
        o_write_enable = 1'b0;
        o_byte_enable  = '0;
        o_write_addr   = '0;
        o_write_data   = '0;
        if (grant_ok) begin
            o_m_grant[win] = 1'b1;
            o_read_req     = i_m_read_req[win];
            o_read_addr    = i_m_read_addr[int'(win)*ADDR_W +: ADDR_W];
            o_write_enable = i_m_write_enable[win];
            o_byte_enable  = i_m_byte_enable[int'(win)*BE_W +: BE_W];
            o_write_addr   = i_m_write_addr[int'(win)*ADDR_W +: ADDR_W];
            o_write_data   = i_m_write_data[int'(win)*DATA_W +: DATA_W];
        end
    end

    // Return pipeline steps with clk_en so it stays aligned with the gated RAM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
            idx_q <= '0;
        end else if (clk_en) begin
            vld_q[0] <= o_read_req;
            idx_q[0] <= win;
            for (int unsigned i = 1; i < READ_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                idx_q[i] <= idx_q[i-1];
            end
        end
    end

    always_comb begin
        o_m_read_valid = '0;
        if (rst && clk_en && vld_q[READ_LAT-1]) begin
            o_m_read_valid[idx_q[READ_LAT-1]] = 1'b1;
        end
    end

    assign o_m_read_data = i_read_data;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Directed bench for ram_bus_arbiter: a 3-master READ_LAT=1 instance and a 3-master READ_LAT=3 instance share stimulus.
module tb_ram_bus_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int NV = 15;

    typedef struct {
        logic       lk;
        logic [1:0] lm;
        logic [2:0] rd;
        logic [2:0] wr;
        logic [2:0] g;
        logic [2:0] rv;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            clk_en;
    logic            lock_en;
    logic [1:0]      lock_master;
    logic [N-1:0]    rd_req;
    logic [N-1:0]    wr_en;
    logic [N*AW-1:0] rd_addr_p;
    logic [N*AW-1:0] wr_addr_p;
    logic [N*BW-1:0] be_p;
    logic [N*DW-1:0] wr_data_p;

    logic [N-1:0]  g1, rv1, g3, rv3;
    logic [DW-1:0] rdata1, rdata3, ram_data1, ram_data3;
    logic          rreq1, rreq3, we1, we3;
    logic [AW-1:0] raddr1, raddr3, waddr1, waddr3;
    logic [BW-1:0] be1, be3;
    logic [DW-1:0] wdata1, wdata3;

    logic [AW-1:0] m_raddr [N];
    logic [AW-1:0] m_waddr [N];
    logic [DW-1:0] m_wdata [N];
    logic [BW-1:0] m_be    [N];
    logic [DW-1:0] r3_q    [3];

    vec_t vecs [NV];
    int   n_cmp;
    int   n_err;

    always #5 clk = ~clk;

    ram_bus_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .clk_en(clk_en), .i_lock_en(lock_en), .i_lock_master(lock_master),
        .i_m_read_req(rd_req), .i_m_read_addr(rd_addr_p), .i_m_write_enable(wr_en),
        .i_m_byte_enable(be_p), .i_m_write_addr(wr_addr_p), .i_m_write_data(wr_data_p),
        .o_m_grant(g1), .o_m_read_valid(rv1), .o_m_read_data(rdata1),
        .o_read_req(rreq1), .o_read_addr(raddr1), .i_read_data(ram_data1),
        .o_write_enable(we1), .o_byte_enable(be1), .o_write_addr(waddr1), .o_write_data(wdata1)
    );

    ram_bus_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst), .clk_en(clk_en), .i_lock_en(lock_en), .i_lock_master(lock_master),
        .i_m_read_req(rd_req), .i_m_read_addr(rd_addr_p), .i_m_write_enable(wr_en),
        .i_m_byte_enable(be_p), .i_m_write_addr(wr_addr_p), .i_m_write_data(wr_data_p),
        .o_m_grant(g3), .o_m_read_valid(rv3), .o_m_read_data(rdata3),
        .o_read_req(rreq3), .o_read_addr(raddr3), .i_read_data(ram_data3),
        .o_write_enable(we3), .o_byte_enable(be3), .o_write_addr(waddr3), .o_write_data(wdata3)
    );

    function automatic logic [DW-1:0] ram_f(input logic [AW-1:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    // RAM stand-ins: contents are a fixed function of the address, latency matches each instance.
    always @(posedge clk) begin
        if (clk_en) begin
            ram_data1 <= ram_f(raddr1);
            r3_q[0]   <= ram_f(raddr3);
            r3_q[1]   <= r3_q[0];
            r3_q[2]   <= r3_q[1];
        end
    end
    assign ram_data3 = r3_q[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic [2:0] g);
        logic [AW-1:0] era, ewa;
        logic [DW-1:0] ewd;
        logic [BW-1:0] ebe;
        logic          err, ewe;
        era = '0; ewa = '0; ewd = '0; ebe = '0; err = 1'b0; ewe = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (g[k]) begin
                era = m_raddr[k]; ewa = m_waddr[k]; ewd = m_wdata[k]; ebe = m_be[k];
                err = rd_req[k];  ewe = wr_en[k];
            end
        end
        check({tag, ".grant1"}, 32'(g1), 32'(g));
        check({tag, ".grant3"}, 32'(g3), 32'(g));
        check({tag, ".read_req"}, 32'(rreq1), 32'(err));
        check({tag, ".write_en"}, 32'(we1), 32'(ewe));
        check({tag, ".read_addr"}, raddr1, era);
        check({tag, ".write_addr"}, waddr1, ewa);
        check({tag, ".byte_en"}, 32'(be1), 32'(ebe));
        check({tag, ".write_data"}, wdata1, ewd);
    endtask

    task automatic chk_rv1(input string tag, input logic [2:0] rv);
        check({tag, ".rvalid1"}, 32'(rv1), 32'(rv));
        for (int k = 0; k < N; k++) begin
            if (rv[k]) check({tag, ".rdata1"}, rdata1, ram_f(m_raddr[k]));
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        m_raddr = '{32'h10, 32'h50, 32'h90};
        m_waddr = '{32'h100, 32'h20, 32'h300};
        m_wdata = '{32'h0123_4567, 32'hDEAD_BEEF, 32'hCAFE_F00D};
        m_be    = '{4'b1111, 4'b0011, 4'b1000};
        for (int k = 0; k < N; k++) begin
            rd_addr_p[k*AW +: AW] = m_raddr[k];
            wr_addr_p[k*AW +: AW] = m_waddr[k];
            wr_data_p[k*DW +: DW] = m_wdata[k];
            be_p[k*BW +: BW]      = m_be[k];
        end

        //           lk    lm     rd      wr      grant   rvalid1
        vecs[0]  = '{1'b0, 2'd0, 3'b111, 3'b000, 3'b001, 3'b000};
        vecs[1]  = '{1'b0, 2'd0, 3'b111, 3'b000, 3'b010, 3'b001};
        vecs[2]  = '{1'b0, 2'd0, 3'b111, 3'b000, 3'b100, 3'b010};
        vecs[3]  = '{1'b0, 2'd0, 3'b111, 3'b000, 3'b001, 3'b100};
        vecs[4]  = '{1'b0, 2'd0, 3'b111, 3'b000, 3'b010, 3'b001};
        vecs[5]  = '{1'b0, 2'd0, 3'b111, 3'b000, 3'b100, 3'b010};
        vecs[6]  = '{1'b0, 2'd0, 3'b000, 3'b000, 3'b000, 3'b100};
        vecs[7]  = '{1'b1, 2'd1, 3'b011, 3'b000, 3'b010, 3'b000};
        vecs[8]  = '{1'b1, 2'd1, 3'b011, 3'b000, 3'b010, 3'b010};
        vecs[9]  = '{1'b0, 2'd1, 3'b011, 3'b000, 3'b001, 3'b010};
        vecs[10] = '{1'b1, 2'd3, 3'b111, 3'b000, 3'b000, 3'b001};
        vecs[11] = '{1'b0, 2'd0, 3'b000, 3'b010, 3'b010, 3'b000};
        vecs[12] = '{1'b0, 2'd0, 3'b101, 3'b001, 3'b100, 3'b000};
        vecs[13] = '{1'b0, 2'd0, 3'b101, 3'b001, 3'b001, 3'b100};
        vecs[14] = '{1'b0, 2'd0, 3'b000, 3'b000, 3'b000, 3'b001};

        // Reset held with every master requesting.
        rst = 1'b1; clk_en = 1'b1; lock_en = 1'b0; lock_master = 2'd0;
        rd_req = '1; wr_en = '1;
        #1 rst = 1'b0;
        next_cycle();
        @(negedge clk);
        chk_bus("reset", 3'b000);
        check("reset.rvalid1", 32'(rv1), 32'd0);
        check("reset.rvalid3", 32'(rv3), 32'd0);
        next_cycle();
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            lock_en = vecs[i].lk; lock_master = vecs[i].lm;
            rd_req  = vecs[i].rd; wr_en = vecs[i].wr;
            @(negedge clk);
            chk_bus($sformatf("v%0d", i), vecs[i].g);
            chk_rv1($sformatf("v%0d", i), vecs[i].rv);
            next_cycle();
        end

        lock_en = 1'b0; lock_master = 2'd0; rd_req = '0; wr_en = '0;
        repeat (4) next_cycle();

        // In-flight read survives a lock switch (READ_LAT=3 instance).
        rd_req = 3'b001;
        @(negedge clk);
        chk_bus("B.issue0", 3'b001);
        next_cycle();
        lock_en = 1'b1; lock_master = 2'd1; rd_req = 3'b010;
        @(negedge clk);
        chk_bus("B.issue1", 3'b010);
        check("B.c1.rvalid3", 32'(rv3), 32'd0);
        next_cycle();
        rd_req = 3'b000;
        @(negedge clk);
        check("B.c2.rvalid3", 32'(rv3), 32'd0);
        next_cycle();
        @(negedge clk);
        check("B.c3.rvalid3", 32'(rv3), 32'b001);
        check("B.c3.rdata3", rdata3, ram_f(32'h10));
        next_cycle();
        @(negedge clk);
        check("B.c4.rvalid3", 32'(rv3), 32'b010);
        check("B.c4.rdata3", rdata3, ram_f(32'h50));
        next_cycle();

        // clk_en stall delays the return by the stalled cycles and blocks grants.
        lock_en = 1'b0; lock_master = 2'd0; rd_req = 3'b100;
        @(negedge clk);
        chk_bus("C.issue", 3'b100);
        next_cycle();
        clk_en = 1'b0; rd_req = 3'b001;
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            chk_bus($sformatf("C.stall%0d", s), 3'b000);
            check($sformatf("C.stall%0d.rvalid1", s), 32'(rv1), 32'd0);
            next_cycle();
        end
        clk_en = 1'b1; rd_req = 3'b000;
        @(negedge clk);
        chk_rv1("C.resume", 3'b100);
        next_cycle();
        @(negedge clk);
        chk_rv1("C.after", 3'b000);
        next_cycle();

        // Reset right after a read issue discards the pending return.
        rd_req = 3'b001;
        @(negedge clk);
        chk_bus("D.issue", 3'b001);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk_bus("D.inreset", 3'b000);
        check("D.inreset.rvalid1", 32'(rv1), 32'd0);
        check("D.inreset.rvalid3", 32'(rv3), 32'd0);
        next_cycle();
        rst = 1'b1; rd_req = 3'b000;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("D.post%0d.rvalid1", c), 32'(rv1), 32'd0);
            check($sformatf("D.post%0d.rvalid3", c), 32'(rv3), 32'd0);
            next_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ram_bus_arbiter.md
# ram_bus_arbiter

Parametrised N-master arbiter in front of the shared RAM data port (read + byte-enabled write). It generalises the fixed two-way boot/core select: any number of bus masters, with round-robin arbitration and an optional exclusive-ownership lock (used for the boot-loader phase). It also has a read-return pipeline that routes `i_read_data` back to the master that issued the read. It sits between the masters (core, BIOS, future DMA) and `ram`; the instruction-fetch port is not arbitrated.

## Interface
- `N_MASTERS`, 2, number of masters (2..8)
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width (multiple of 8)
- `READ_LAT`, 1, RAM read latency in cycles (1..4)
- `MIDX_W`, derived `$clog2(N_MASTERS)`, master index width (min 1)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `clk_en`  in  1  cycle enable; low = freeze all state, no RAM access
- `i_lock_en`  in  1  exclusive mode: only `i_lock_master` may be granted
- `i_lock_master`  in  MIDX_W  master owning the bus when locked
- `i_m_read_req`  in  N_MASTERS  per-master read request
- `i_m_read_addr`  in  N_MASTERS*ADDR_W  packed, master k at [k*ADDR_W +: ADDR_W]
- `i_m_write_enable`  in  N_MASTERS  per-master write request
- `i_m_byte_enable`  in  N_MASTERS*DATA_W/8  packed byte enables
- `i_m_write_addr`  in  N_MASTERS*ADDR_W  packed write addresses
- `i_m_write_data`  in  N_MASTERS*DATA_W  packed write data
- `o_m_grant`  out  N_MASTERS  one-hot grant, combinational, this cycle
- `o_m_read_valid`  out  N_MASTERS  one-hot read-data-valid
- `o_m_read_data`  out  DATA_W  read data, broadcast to all masters
- `o_read_req`  out  1  to RAM
- `o_read_addr`  out  ADDR_W  to RAM
- `i_read_data`  in  DATA_W  from RAM
- `o_write_enable`  out  1  to RAM
- `o_byte_enable`  out  DATA_W/8  to RAM
- `o_write_addr`  out  ADDR_W  to RAM
- `o_write_data`  out  DATA_W  to RAM

## Operation
- Master k is "requesting" when `i_m_read_req[k] | i_m_write_enable[k]`.
- Eligible set:
  - when `i_lock_en` = 1: only `i_lock_master`;
  - otherwise: all requesting masters.
  - An out-of-range `i_lock_master` makes no master eligible.
- Winner (round-robin): the first eligible master searching upward from `rr_ptr`, wrapping at N_MASTERS-1 → 0.
- Granting master w:
  - `o_m_grant[w]`=1.
  - w's read and write fields are forwarded to the RAM outputs in the same cycle. Read and write from the same master may coexist.
  - `rr_ptr` ← (w+1) mod N_MASTERS.
- No grant:
  - all RAM request outputs are 0;
  - address/data outputs are 0;
  - `rr_ptr` holds.
- Locked grants still advance `rr_ptr`.
- Ungranted masters hold their request until granted. There is no queueing inside the block.
- Read return pipeline:
  - a READ_LAT-deep shift register of {valid, master index};
  - stage 0 is loaded with {`o_read_req`, w};
  - the last stage drives `o_m_read_valid` (one-hot decode);
  - `o_m_read_data` = `i_read_data` passthrough.
  - The pipeline advances only when `clk_en`=1, consistent with `ram` gating.
- Lock changes do not disturb in-flight reads: data returns to the recorded index.
- `clk_en`=0:
  - grant and RAM request outputs forced to 0;
  - `rr_ptr` and the pipeline hold.

## Timing
- Reset (`rst`=0, async):
  - `rr_ptr`=0;
  - pipeline valids cleared;
  - `o_m_grant`=0, `o_m_read_valid`=0, and all RAM outputs 0 while in reset.
- Grant and RAM request: combinational, same cycle as the request (0-cycle arbitration).
- Read data valid: exactly READ_LAT clk_en-cycles after the granted read cycle.
- Throughput: one grant per enabled cycle. Back-to-back reads from different masters return in issue order.
- Reset asserted mid-read: pending returns are discarded; no `o_m_read_valid` after release.
- Simultaneous requests from all masters: each is granted once per N_MASTERS cycles (no starvation, unlocked).

## Configuration
- `ARB_FIXED_PRIORITY_EN` defined:
  - winner = lowest-index eligible master;
  - `rr_ptr` is not implemented; its outputs and behaviour are otherwise identical.
- Undefined (default): round-robin as described.

## Test plan
- Reset: hold `rst`=0 with all requests high → all outputs 0. Release → master 0 granted first (`rr_ptr`=0).
- Round-robin: N_MASTERS=3, all masters request reads continuously → grants 0,1,2,0,1,2. Each `o_m_read_valid[k]` pulses READ_LAT=1 cycle after its grant, with data for the matching address.
- Lock: `i_lock_en`=1, `i_lock_master`=1, masters 0 and 1 requesting → only master 1 granted. Master 0 is granted the first cycle after lock drops.
- In-flight across lock: master 0 reads addr 0x10 with READ_LAT=3, lock asserts to master 1 next cycle → `o_m_read_valid[0]` still fires 3 cycles after issue.
- Write forwarding: master 1 writes 0xDEADBEEF, BE=4'b0011, addr 0x20 → RAM write outputs carry exactly those values in the grant cycle; `o_read_req`=0.
- `clk_en` stall + mid-read reset: drop `clk_en` for 2 cycles after a read → valid delayed 2 cycles. Then assert `rst` after a new read issue → no valid pulse follows.
